// File: rtl/disp_pkg.sv
// Shared types and defaults for the display-ownership arbiter.
// Holds requester count, arbiter state enum, default timing constants.
package disp_pkg;

    localparam int NREQ            = 4;
    localparam int TICK_DIV_DEF    = 100000;
    localparam int HOLD_TICKS_DEF  = 200;
    localparam int BLINK_TICKS_DEF = 500;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_t;

    // Highest-index set bit wins; returns 0 when nothing is set.
    function automatic logic [1:0] pick_hi(input logic [NREQ-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        priority case (1'b1)
            r[3]:    idx = 2'd3;
            r[2]:    idx = 2'd2;
            r[1]:    idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        logic [NREQ-1:0] o;
        o      = '0;
        o[idx] = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Arbitration-tick prescaler: one-cycle tick every TICK_DIV clocks.
// Ports: clk, rst (sync, active-high) in; tick out.
module disp_tick_gen
    import disp_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/disp_arbiter.sv
// Priority arbiter granting a shared seven-segment display, with hold time.
// Ports: clk, rst (sync, active-high), req[3:0], req_data[63:0], req_blink[3:0]
//        in; gnt[3:0], disp_data[15:0], disp_blank out. Optional blinking via
//        DISP_ARBITER_BLINK_EN.
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
    parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] req_data,
    input  logic [3:0]  req_blink,
    output logic [3:0]  gnt,
    output logic [15:0] disp_data,
    output logic        disp_blank
);

    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HW-1:0] HLOAD = HW'(HOLD_TICKS);

    logic          tick;
    state_t        state, nstate;
    logic [1:0]    owner, nowner;
    logic [HW-1:0] hcnt, ncnt;
    logic [1:0]    hi;
    logic          any;
    logic          blink_on;

    disp_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

`ifdef DISP_ARBITER_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] bcnt;
    logic          phase;

    // Free-running phase, independent of ownership changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            if (bcnt == BW'(BLINK_TICKS - 1)) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    assign blink_on = phase & req_blink[owner];
`else
    logic unused_blink;
    assign unused_blink = ^req_blink;
    assign blink_on     = 1'b0;
`endif

    assign hi  = pick_hi(req);
    assign any = |req;

    always_comb begin
        nstate = state;
        nowner = owner;
        ncnt   = hcnt;
        unique case (state)
            IDLE: begin
                if (any) begin
                    nstate = HOLD;
                    nowner = hi;
                    ncnt   = HLOAD;
                end
            end
            HOLD: begin
                // Release outranks the hold timer; owner bit is
                // already clear so hi is the best remaining requester.
                if (!req[owner]) begin
                    if (any) begin
                        nstate = HOLD;
                        nowner = hi;
                        ncnt   = HLOAD;
                    end else begin
                        nstate = IDLE;
                        ncnt   = '0;
                    end
                end else if (tick) begin
                    if (hcnt <= HW'(1)) begin
                        nstate = OPEN;
                        ncnt   = '0;
                    end else begin
                        ncnt = hcnt - HW'(1);
                    end
                end
            end
            OPEN: begin
                if (!req[owner]) begin
                    if (any) begin
                        nstate = HOLD;
                        nowner = hi;
                        ncnt   = HLOAD;
                    end else begin
                        nstate = IDLE;
                        ncnt   = '0;
                    end
                end else if (hi > owner) begin
                    nstate = HOLD;
                    nowner = hi;
                    ncnt   = HLOAD;
                end
            end
            default: begin
                nstate = IDLE;
                ncnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 2'd0;
            hcnt       <= '0;
            gnt        <= '0;
            disp_data  <= '0;
            disp_blank <= 1'b1;
        end else begin
            state      <= nstate;
            owner      <= nowner;
            hcnt       <= ncnt;
            gnt        <= (nstate == IDLE) ? '0 : onehot(nowner);
            // Data follows the registered owner, one cycle behind gnt.
            disp_data  <= (state == IDLE) ? '0
                        : req_data[{owner, 4'b0000} +: 16];
            disp_blank <= (state == IDLE) | blink_on;
        end
    end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per arbitration tick (1 kHz at 100 MHz).
REQ-002 SHALL have parameter HOLD_TICKS, default 200, minimum ownership time in ticks.
REQ-003 SHALL have parameter BLINK_TICKS, default 500, ticks per blink half-period.
REQ-004 SHALL have port clk  in  1  system clock, single clock domain.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  in  4  display requests; bit 3 highest priority (alarm), bit 0 lowest (time-of-day).
REQ-007 SHALL have port req_data  in  64  packed 16-bit display words; requester i uses bits [16i+15:16i].
REQ-008 SHALL have port req_blink  in  4  per-requester blink request.
REQ-009 SHALL have port gnt  out  4  one-hot grant, or all-zero.
REQ-010 SHALL have port disp_data  out  16  word forwarded to the seven-segment display driver.
REQ-011 SHALL have port disp_blank  out  1  high = display blanked.

Function
REQ-012 SHALL implement states IDLE (no owner), HOLD (owner locked, hold counter running), OPEN (owner may be preempted).
REQ-013 SHALL generate a one-cycle internal tick every TICK_DIV clk cycles; prescaler wraps from TICK_DIV-1 to 0.
REQ-014 IDLE: any req bit set -> grant highest-index set bit, load hold counter with HOLD_TICKS, go HOLD; gnt visible the next cycle.
REQ-015 HOLD: hold counter decrements on each tick; reaching 0 -> OPEN; higher-priority requests SHALL NOT preempt.
REQ-016 OPEN: each cycle re-arbitrate; if a higher-index req is set, grant it next cycle, reload hold counter, go HOLD; otherwise keep owner.
REQ-017 In HOLD or OPEN, owner deasserting req SHALL release next cycle: grant highest remaining req (-> HOLD, reload) or go IDLE if none.
REQ-018 Owner drop and higher request in the same cycle SHALL resolve as release then arbitrate (new owner, no idle cycle).
REQ-019 gnt, disp_data and disp_blank SHALL be registered; disp_data SHALL equal owner's req_data word, sampled every cycle, one-cycle latency.
REQ-020 IDLE: gnt=0, disp_data=16'h0000, disp_blank=1.
REQ-021 Owned states: disp_blank=0 except per REQ-025.
REQ-022 Hold counter SHALL be wide enough for HOLD_TICKS; HOLD_TICKS=0 SHALL enter OPEN on the next tick.

Reset
REQ-023 rst high SHALL force IDLE, prescaler=0, hold counter=0, blink phase=0, gnt=0, disp_data=0, disp_blank=1 on the next edge, including mid-HOLD.
REQ-024 First grant after rst release SHALL follow REQ-014 with no extra delay.

Configuration
REQ-025 With DISP_ARBITER_BLINK_EN defined: blink phase toggles every BLINK_TICKS ticks, free-running; disp_blank=1 when owner's req_blink=1 and phase=1.
REQ-026 Without DISP_ARBITER_BLINK_EN: req_blink ignored, no blink counter, disp_blank high only in IDLE.

Structure
REQ-027 Package disp_pkg SHALL hold NREQ=4, the state enum (IDLE/HOLD/OPEN), and default TICK_DIV/HOLD_TICKS/BLINK_TICKS constants.
REQ-028 Sub-module disp_tick_gen SHALL implement the prescaler (clk, rst in; tick out); everything else inline.

Verification (bench params TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2)
REQ-029 rst, then req=4'b0101, word0=16'h1234, word2=16'h0830 -> next cycle gnt=4'b0100; following cycle disp_data=16'h0830, disp_blank=0.
REQ-030 Owner=0 in HOLD, raise req[3] -> gnt stays 4'b0001 for 12 cycles (3 ticks), then gnt=4'b1000 within 1 cycle.
REQ-031 Owner=3, drop req[3] while req[1]=1 -> gnt=4'b0010 next cycle; drop all -> gnt=0, disp_data=0, disp_blank=1.
REQ-032 Assert rst mid-HOLD with req=4'b1111 -> gnt=0, disp_blank=1 next edge; release rst -> gnt=4'b1000 next cycle.
REQ-033 BLINK_EN, owner req_blink=1 -> disp_blank alternates 8 cycles high / 8 cycles low; without macro disp_blank stays 0.
